cache_refill_arbiter: RTL and testbench

Shares the single memory-side AXI read channel (AR/R) between the instruction-cache and data-cache refill engines. It latches a grant when a refill request appears and holds it from the address handshake through the last data beat. It routes the R channel only to the owner and flags malformed burst lengths. It sits between the two cache miss FSMs and the memory/bus interface.

---
 rtl/cache_refill_arbiter_pkg.sv | 24 ++
 rtl/cache_refill_arbiter_if.sv | 59 +++++
 rtl/refill_beat_counter.sv | 54 +++++
 rtl/cache_refill_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_refill_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_refill_arbiter_pkg.sv
// Shared definitions for the cache refill arbiter.
//   state_e         : arbiter FSM encoding (idle / address phase / data phase)
//   OWN_I / OWN_D   : owner encoding, icache = 0, dcache = 1
//   DEF_LINE_BEATS  : default beats per cache-line refill
//   beat_cnt_w()    : width of the beat counter for a given line length
package cache_refill_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int unsigned DEF_LINE_BEATS = 4;

  // One extra bit so the counter can represent LINE_BEATS itself (the overrun value).
  function automatic int unsigned beat_cnt_w(input int unsigned beats);
    return int'($clog2(beats)) + 1;
  endfunction

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// Handshake bundle for the cache refill arbiter.
//   i_*  : icache refill AR/R handshake
//   d_*  : dcache refill AR/R handshake
//   r_data : beat data broadcast to both caches
//   m_*  : shared memory-side AXI read channel (AR/R)
// Modports:
//   master : the arbiter
//   slave  : the caches plus memory (environment)
interface cache_refill_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              i_arvalid;
  logic [ADDR_W-1:0] i_araddr;
  logic              i_arready;
  logic              i_rvalid;
  logic              i_rlast;
  logic              i_rready;

  logic              d_arvalid;
  logic [ADDR_W-1:0] d_araddr;
  logic              d_arready;
  logic              d_rvalid;
  logic              d_rlast;
  logic              d_rready;

  logic [DATA_W-1:0] r_data;

  logic              m_arvalid;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic              m_arready;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rlast;
  logic              m_rready;

  modport master (
    input  i_arvalid, i_araddr, i_rready,
    input  d_arvalid, d_araddr, d_rready,
    input  m_arready, m_rvalid, m_rdata, m_rlast,
    output i_arready, i_rvalid, i_rlast,
    output d_arready, d_rvalid, d_rlast,
    output r_data,
    output m_arvalid, m_araddr, m_arlen, m_rready
  );

  modport slave (
    output i_arvalid, i_araddr, i_rready,
    output d_arvalid, d_araddr, d_rready,
    output m_arready, m_rvalid, m_rdata, m_rlast,
    input  i_arready, i_rvalid, i_rlast,
    input  d_arready, d_rvalid, d_rlast,
    input  r_data,
    input  m_arvalid, m_araddr, m_arlen, m_rready
  );

endinterface

// File: rtl/refill_beat_counter.sv
// Beat counter for one refill burst with burst-length checking.
//   clk, rstn : clock, asynchronous active-low reset
//   clear     : restart the count (address handshake completing)
//   beat      : a data beat is accepted this cycle
//   last      : the accepted beat carries rlast
//   len_err   : sticky; set when rlast arrives on the wrong beat or the burst
//               runs past LINE_BEATS without rlast. Cleared only by reset.
module refill_beat_counter
  import cache_refill_arbiter_pkg::*;
#(
  parameter int unsigned LINE_BEATS = DEF_LINE_BEATS
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic beat,
  input  logic last,
  output logic len_err
);

  localparam int unsigned CntW = beat_cnt_w(LINE_BEATS);
  localparam logic [CntW-1:0] LastIdx = CntW'(LINE_BEATS - 1);
  localparam logic [CntW-1:0] Full    = CntW'(LINE_BEATS);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear) begin
      cnt_d = '0;
    end else if (beat) begin
      // Saturate at LINE_BEATS so an overlong burst keeps flagging instead of wrapping.
      if (cnt_q != Full) cnt_d = cnt_q + CntW'(1);
      if (last && (cnt_q != LastIdx)) err_d = 1'b1;
      // Count would reach LINE_BEATS with no rlast in sight.
      if (!last && (cnt_q >= LastIdx)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign len_err = err_q;

endmodule

// File: rtl/cache_refill_arbiter.sv
// Arbiter sharing one memory-side AXI read channel between the icache and
// dcache refill engines. A grant is latched in IDLE and held from the address
// handshake through the last data beat; R is routed only to the owner.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : cache_refill_arbiter_if.master (cache AR/R, memory AR/R, r_data)
//   busy      : FSM not idle
//   owner     : 0 = icache, 1 = dcache; meaningful while busy
//   len_err   : sticky malformed-burst-length flag
// Build option: define CACHE_ARB_RR_EN for round-robin on contention;
// otherwise the dcache always wins.
module cache_refill_arbiter
  import cache_refill_arbiter_pkg::*;
#(
  parameter int unsigned LINE_BEATS = DEF_LINE_BEATS,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  cache_refill_arbiter_if.master bus,
  output logic                   busy,
  output logic                   owner,
  output logic                   len_err
);

  state_e state_q;
  logic   owner_q;
  logic   grant_sel;
  logic   ar_hs;
  logic   beat;

`ifdef CACHE_ARB_RR_EN
  logic last_owner_q;

  always_comb begin
    grant_sel = bus.d_arvalid ? OWN_D : OWN_I;
    if (bus.i_arvalid && bus.d_arvalid) grant_sel = ~last_owner_q;
  end
`else
  always_comb begin
    grant_sel = bus.d_arvalid ? OWN_D : OWN_I;
  end
`endif

  assign ar_hs = (state_q == StAddr) && bus.m_arvalid && bus.m_arready;
  assign beat  = (state_q == StData) && bus.m_rvalid && bus.m_rready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      owner_q      <= OWN_I;
`ifdef CACHE_ARB_RR_EN
      last_owner_q <= OWN_I;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.i_arvalid || bus.d_arvalid) begin
            owner_q <= grant_sel;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (ar_hs) begin
            state_q      <= StData;
`ifdef CACHE_ARB_RR_EN
            last_owner_q <= owner_q;
`endif
          end
        end
        StData: begin
          // Only rlast ends the burst; the length checker just flags.
          if (beat && bus.m_rlast) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake routing is combinational so the arbiter adds no latency.
  always_comb begin
    bus.i_arready = 1'b0;
    bus.d_arready = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_rlast   = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rlast   = 1'b0;
    bus.r_data    = {DATA_W{1'b0}};
    bus.m_arvalid = 1'b0;
    bus.m_araddr  = {ADDR_W{1'b0}};
    bus.m_rready  = 1'b0;
    unique case (state_q)
      StAddr: begin
        if (owner_q == OWN_D) begin
          bus.m_arvalid = bus.d_arvalid;
          bus.m_araddr  = bus.d_araddr;
          bus.d_arready = bus.m_arready;
        end else begin
          bus.m_arvalid = bus.i_arvalid;
          bus.m_araddr  = bus.i_araddr;
          bus.i_arready = bus.m_arready;
        end
      end
      StData: begin
        bus.r_data = bus.m_rdata;
        if (owner_q == OWN_D) begin
          bus.d_rvalid = bus.m_rvalid;
          bus.d_rlast  = bus.m_rlast;
          bus.m_rready = bus.d_rready;
        end else begin
          bus.i_rvalid = bus.m_rvalid;
          bus.i_rlast  = bus.m_rlast;
          bus.m_rready = bus.i_rready;
        end
      end
      default: ;
    endcase
  end

  assign bus.m_arlen = 8'(LINE_BEATS - 1);
  assign busy        = (state_q != StIdle);
  assign owner       = owner_q;

  refill_beat_counter #(
    .LINE_BEATS(LINE_BEATS)
  ) u_beat_counter (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (ar_hs),
    .beat   (beat),
    .last   (bus.m_rlast),
    .len_err(len_err)
  );

endmodule

// File: tb/tb_cache_refill_arbiter.sv
module tb_cache_refill_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] IADDR  = 32'h1C00_0040;
  localparam logic [31:0] DADDR  = 32'h2000_0080;
  localparam logic [31:0] IADDR2 = 32'h1C00_0100;
  localparam logic [31:0] DADDR2 = 32'h2000_0200;

  logic clk;
  logic rstn;
  logic busy;
  logic owner;
  logic len_err;

  int checks;
  int passed;

  cache_refill_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_refill_arbiter #(
    .LINE_BEATS(4),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus    (bus),
    .busy   (busy),
    .owner  (owner),
    .len_err(len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Grant from IDLE with the requester's arvalid already raised; completes the
  // address handshake and drops that requester's arvalid afterwards.
  task automatic grant(input logic own_d, input logic [31:0] addr);
    bus.m_arready = 1'b1;
    tick();
    settle();
    chk("grant_busy", busy, 1'b1);
    chk("grant_owner", owner, own_d);
    chk("grant_m_arvalid", bus.m_arvalid, 1'b1);
    chk("grant_m_araddr", bus.m_araddr, addr);
    chk("grant_own_arready", own_d ? bus.d_arready : bus.i_arready, 1'b1);
    chk("grant_other_arready", own_d ? bus.i_arready : bus.d_arready, 1'b0);
    tick();
    if (own_d) bus.d_arvalid = 1'b0;
    else bus.i_arvalid = 1'b0;
    bus.m_arready = 1'b0;
    settle();
    chk("data_m_arvalid", bus.m_arvalid, 1'b0);
    chk("data_busy", busy, 1'b1);
  endtask

  // Memory returns n beats, rlast on the final one.
  task automatic run_burst(input logic own_d, input int n, input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = base + 32'(b);
      bus.m_rlast  = (b == n - 1);
      settle();
      chk("beat_own_rvalid", own_d ? bus.d_rvalid : bus.i_rvalid, 1'b1);
      chk("beat_other_rvalid", own_d ? bus.i_rvalid : bus.d_rvalid, 1'b0);
      chk("beat_own_rlast", own_d ? bus.d_rlast : bus.i_rlast, (b == n - 1));
      chk("beat_r_data", bus.r_data, base + 32'(b));
      chk("beat_m_rready", bus.m_rready, 1'b1);
      tick();
    end
    chk("post_burst_busy", busy, 1'b0);
    chk("post_burst_rvalid", own_d ? bus.d_rvalid : bus.i_rvalid, 1'b0);
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    bus.m_rdata  = '0;
  endtask

  initial begin
    logic exp_first;

    checks = 0;
    passed = 0;
    rstn          = 1'b0;
    bus.i_arvalid = 1'b0;
    bus.i_araddr  = '0;
    bus.i_rready  = 1'b1;
    bus.d_arvalid = 1'b0;
    bus.d_araddr  = '0;
    bus.d_rready  = 1'b1;
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rdata   = '0;
    bus.m_rlast   = 1'b0;

    // Reset state
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_m_arvalid", bus.m_arvalid, 1'b0);
    chk("rst_m_araddr", bus.m_araddr, 32'h0);
    chk("rst_m_arlen", bus.m_arlen, 8'd3);
    chk("rst_m_rready", bus.m_rready, 1'b0);
    chk("rst_i_arready", bus.i_arready, 1'b0);
    tick();
    rstn = 1'b1;

    // Icache miss with m_arready held low for 5 cycles
    bus.i_arvalid = 1'b1;
    bus.i_araddr  = IADDR;
    settle();
    chk("idle_m_arvalid", bus.m_arvalid, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_m_arvalid", bus.m_arvalid, 1'b1);
      chk("stall_m_araddr", bus.m_araddr, IADDR);
      chk("stall_busy", busy, 1'b1);
      chk("stall_i_arready", bus.i_arready, 1'b0);
      tick();
    end
    bus.m_arready = 1'b1;
    settle();
    chk("hs_i_arready", bus.i_arready, 1'b1);
    chk("hs_d_arready", bus.d_arready, 1'b0);
    tick();
    bus.i_arvalid = 1'b0;
    bus.m_arready = 1'b0;
    // Owner's rready gates m_rready
    bus.i_rready = 1'b0;
    settle();
    chk("rready_gate", bus.m_rready, 1'b0);
    bus.i_rready = 1'b1;
    run_burst(1'b0, 4, 32'hA000_0000);
    chk("i_burst_len_err", len_err, 1'b0);

    // Contention twice: D then I each time (last_owner is I before each round)
    for (int r = 0; r < 2; r++) begin
      bus.i_arvalid = 1'b1;
      bus.i_araddr  = IADDR2;
      bus.d_arvalid = 1'b1;
      bus.d_araddr  = DADDR;
      grant(1'b1, DADDR);
      run_burst(1'b1, 4, 32'hD000_0000);
      // Dead cycle: icache request still held, FSM only now in IDLE
      chk("dead_m_arvalid", bus.m_arvalid, 1'b0);
      grant(1'b0, IADDR2);
      run_burst(1'b0, 4, 32'hB000_0000);
    end

    // Dcache-only burst, then contention: round-robin favours the icache
    bus.d_arvalid = 1'b1;
    bus.d_araddr  = DADDR2;
    grant(1'b1, DADDR2);
    run_burst(1'b1, 4, 32'hC000_0000);
`ifdef CACHE_ARB_RR_EN
    exp_first = 1'b0;
`else
    exp_first = 1'b1;
`endif
    bus.i_arvalid = 1'b1;
    bus.i_araddr  = IADDR;
    bus.d_arvalid = 1'b1;
    bus.d_araddr  = DADDR;
    grant(exp_first, exp_first ? DADDR : IADDR);
    run_burst(exp_first, 4, 32'hE000_0000);
    grant(~exp_first, exp_first ? IADDR : DADDR);
    run_burst(~exp_first, 4, 32'hF000_0000);
    chk("pre_short_len_err", len_err, 1'b0);

    // Short burst: rlast on beat 3
    bus.i_arvalid = 1'b1;
    bus.i_araddr  = IADDR;
    grant(1'b0, IADDR);
    run_burst(1'b0, 3, 32'h1111_0000);
    chk("short_len_err", len_err, 1'b1);
    bus.i_arvalid = 1'b1;
    grant(1'b0, IADDR);
    run_burst(1'b0, 4, 32'h2222_0000);
    chk("sticky_len_err", len_err, 1'b1);

    // Reset during beat 2 of a burst
    bus.i_arvalid = 1'b1;
    grant(1'b0, IADDR);
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h3333_0000;
    tick();
    bus.m_rdata = 32'h3333_0001;
    settle();
    chk("rst_mid_pre_rvalid", bus.i_rvalid, 1'b1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_rvalid", bus.i_rvalid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_m_rready", bus.m_rready, 1'b0);
    chk("rst_mid_r_data", bus.r_data, 32'h0);
    chk("rst_mid_len_err", len_err, 1'b0);
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
    tick();
    rstn = 1'b1;
    bus.d_arvalid = 1'b1;
    bus.d_araddr  = DADDR2;
    grant(1'b1, DADDR2);
    run_burst(1'b1, 4, 32'h4444_0000);
    chk("final_len_err", len_err, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
